temp_ascii_formatter: RTL and testbench

//  Converts one DS18B20 reading (unsigned magnitude + sign) into a fixed-width ASCII frame
//  "<s>DDD.FF\r\n" and streams it byte-by-byte over a valid/ready interface to the UART

---
 rtl/temp_ascii_formatter_pkg.sv | 37 +++
 rtl/temp_ascii_formatter_bin2bcd_seq.sv | 37 +++
 rtl/temp_ascii_formatter.sv | 137 +++++++++++++
 tb/tb_temp_ascii_formatter.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/temp_ascii_formatter_pkg.sv
// Shared constants, FSM encoding and BCD helpers for the ASCII temperature formatter.
package temp_ascii_formatter_pkg;

    localparam logic [7:0] ASCII_PLUS  = 8'h2B;
    localparam logic [7:0] ASCII_MINUS = 8'h2D;
    localparam logic [7:0] ASCII_DOT   = 8'h2E;
    localparam logic [7:0] ASCII_CR    = 8'h0D;
    localparam logic [7:0] ASCII_LF    = 8'h0A;
    localparam logic [7:0] ASCII_ZERO  = 8'h30;

    localparam int unsigned FRAME_LEN_CRLF = 9;
    localparam int unsigned FRAME_LEN_BARE = 7;
    localparam int unsigned CONV_CYCLES    = 7;
    localparam int unsigned BIN_W          = 7;
    localparam int unsigned BCD_W          = 12;
    localparam int unsigned MAG_W          = 11;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CONVERT = 2'd1,
        ST_SEND    = 2'd2
    } state_t;

    // One double-dabble iteration: add-3 correction on each digit, then shift in the next bit.
    function automatic logic [BCD_W-1:0] dd_step(input logic [BCD_W-1:0] bcd, input logic bin_msb);
        logic [BCD_W-1:0] adj;
        for (int d = 0; d < 3; d++) begin
            adj[d*4 +: 4] = (bcd[d*4 +: 4] >= 4'd5) ? bcd[d*4 +: 4] + 4'd3 : bcd[d*4 +: 4];
        end
        return BCD_W'({adj, bin_msb});
    endfunction

    function automatic logic [7:0] bcd_char(input logic [BCD_W-1:0] bcd, input int unsigned pos);
        return ASCII_ZERO + 8'(bcd[pos*4 +: 4]);
    endfunction

endpackage

// File: rtl/temp_ascii_formatter_bin2bcd_seq.sv
// Sequential 7-bit double-dabble: one bit per cycle after load, three BCD digits out.
module bin2bcd_seq
    import temp_ascii_formatter_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic [BIN_W-1:0] i_bin,
    output logic [BCD_W-1:0] o_bcd,
    output logic             o_last_c
);

    logic [BIN_W-1:0] r_shift;
    logic [BCD_W-1:0] r_bcd;
    logic [2:0]       r_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_shift <= '0;
            r_bcd   <= '0;
            r_cnt   <= '0;
        end else if (i_load) begin
            r_shift <= i_bin;
            r_bcd   <= '0;
            r_cnt   <= 3'(CONV_CYCLES);
        end else if (r_cnt != 3'd0) begin
            r_bcd   <= dd_step(r_bcd, r_shift[BIN_W-1]);
            r_shift <= {r_shift[BIN_W-2:0], 1'b0};
            r_cnt   <= r_cnt - 3'd1;
        end
    end

    // High during the cycle whose closing edge performs the final shift.
    assign o_last_c = (r_cnt == 3'd1);
    assign o_bcd    = r_bcd;

endmodule

// File: rtl/temp_ascii_formatter.sv
// Formats one DS18B20 reading as "<s>DDD.FF[\r\n]" and streams it over valid/ready.
module temp_ascii_formatter
    import temp_ascii_formatter_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned FRAC_BITS  = 4,
    parameter int unsigned EMIT_CRLF  = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] temp_data,
    input  logic                  sign,
    output logic [7:0]            tx_data,
    output logic                  tx_valid,
    input  logic                  tx_ready,
    output logic                  busy,
    output logic                  done
);

    localparam int unsigned FRAME_LEN = (EMIT_CRLF != 0) ? FRAME_LEN_CRLF : FRAME_LEN_BARE;
    localparam logic [3:0]  LAST_IDX  = 4'(FRAME_LEN - 1);

    state_t           r_state;
    logic [3:0]       r_idx;
    logic             r_neg;
    logic [7:0]       r_tx_data;
    logic             r_tx_valid;
    logic             r_busy;
    logic             r_done;

    logic [MAG_W-1:0] w_mag;
    logic [BIN_W-1:0] w_int_bin;
    logic [BIN_W-1:0] w_hund_bin;
    logic             w_load;
    logic [BCD_W-1:0] w_int_bcd;
    logic [BCD_W-1:0] w_hund_bcd;
    logic             w_int_last_c;
    logic             w_hund_last_c;
    logic [3:0]       w_sel;
    logic [7:0]       w_byte;

    // Out-of-range readings saturate at 127.9375 degC.
    assign w_mag      = (|temp_data[DATA_WIDTH-1:MAG_W]) ? {MAG_W{1'b1}} : temp_data[MAG_W-1:0];
    assign w_int_bin  = w_mag[FRAC_BITS +: BIN_W];
    assign w_hund_bin = BIN_W'((9'(w_mag[3:0]) * 9'd25) >> 2);
    assign w_load     = (r_state == ST_IDLE) && start;

    bin2bcd_seq u_int_bcd (
        .clk      (clk),
        .rst      (rst),
        .i_load   (w_load),
        .i_bin    (w_int_bin),
        .o_bcd    (w_int_bcd),
        .o_last_c (w_int_last_c)
    );

    bin2bcd_seq u_hund_bcd (
        .clk      (clk),
        .rst      (rst),
        .i_load   (w_load),
        .i_bin    (w_hund_bin),
        .o_bcd    (w_hund_bcd),
        .o_last_c (w_hund_last_c)
    );

    // Selects the byte to load next: current index on entry, following index on a handshake.
    always_comb begin
        w_sel  = r_tx_valid ? r_idx + 4'd1 : r_idx;
        w_byte = 8'h00;
        case (w_sel)
            4'd0:    w_byte = r_neg ? ASCII_MINUS : ASCII_PLUS;
            4'd1:    w_byte = bcd_char(w_int_bcd, 2);
            4'd2:    w_byte = bcd_char(w_int_bcd, 1);
            4'd3:    w_byte = bcd_char(w_int_bcd, 0);
            4'd4:    w_byte = ASCII_DOT;
            4'd5:    w_byte = bcd_char(w_hund_bcd, 1);
            4'd6:    w_byte = bcd_char(w_hund_bcd, 0);
            4'd7:    w_byte = ASCII_CR;
            4'd8:    w_byte = ASCII_LF;
            default: w_byte = 8'h00;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_idx      <= '0;
            r_neg      <= 1'b0;
            r_tx_data  <= 8'h00;
            r_tx_valid <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_neg   <= sign && (w_mag != '0);
                        r_busy  <= 1'b1;
                        r_state <= ST_CONVERT;
                    end
                end
                ST_CONVERT: begin
                    if (w_int_last_c && w_hund_last_c) begin
                        r_idx   <= '0;
                        r_state <= ST_SEND;
                    end
                end
                ST_SEND: begin
                    if (!r_tx_valid) begin
                        r_tx_valid <= 1'b1;
                        r_tx_data  <= w_byte;
                    end else if (tx_ready) begin
                        if (r_idx == LAST_IDX) begin
                            r_tx_valid <= 1'b0;
                            r_tx_data  <= 8'h00;
                            r_busy     <= 1'b0;
                            r_done     <= 1'b1;
                            r_state    <= ST_IDLE;
                        end else begin
                            r_idx     <= r_idx + 4'd1;
                            r_tx_data <= w_byte;
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign tx_data  = r_tx_data;
    assign tx_valid = r_tx_valid;
    assign busy     = r_busy;
    assign done     = r_done;

endmodule

// File: tb/tb_temp_ascii_formatter.sv
// Scoreboard bench: expected frame bytes queued at start, checked on each accepted byte.
module tb_temp_ascii_formatter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [15:0] temp_data = 16'h0000;
    logic        sign = 1'b0;
    logic        tx_ready = 1'b1;
    logic [7:0]  tx_data;
    logic        tx_valid, busy, done;

    logic        start2 = 1'b0;
    logic [15:0] temp2 = 16'h0000;
    logic        sign2 = 1'b0;
    logic        ready2 = 1'b1;
    logic [7:0]  tx_data2;
    logic        tx_valid2, busy2, done2;

    always #5 clk = ~clk;

    temp_ascii_formatter #(.DATA_WIDTH(16), .FRAC_BITS(4), .EMIT_CRLF(1)) dut (
        .clk(clk), .rst(rst), .start(start), .temp_data(temp_data), .sign(sign),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready), .busy(busy), .done(done)
    );

    temp_ascii_formatter #(.DATA_WIDTH(16), .FRAC_BITS(4), .EMIT_CRLF(0)) dut_bare (
        .clk(clk), .rst(rst), .start(start2), .temp_data(temp2), .sign(sign2),
        .tx_data(tx_data2), .tx_valid(tx_valid2), .tx_ready(ready2), .busy(busy2), .done(done2)
    );

    typedef struct {
        logic [7:0] b;
        bit         last;
    } exp_t;

    exp_t       q[$];
    int         n_chk = 0;
    int         n_bad = 0;
    int         n_acc = 0;
    int         n_done = 0;
    bit         exp_done = 1'b0;
    bit         prev_stall = 1'b0;
    logic [7:0] prev_data = 8'h00;

    // Monitor: handshake visible at the falling edge is the one taken at the next rising edge.
    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            n_chk++;
            if (done !== exp_done) begin
                n_bad++;
                $display("FAIL done_pulse: got %b want %b at %0t", done, exp_done, $time);
            end
            exp_done = 1'b0;
            if (done === 1'b1) n_done++;
            if (prev_stall) begin
                n_chk++;
                if (tx_valid !== 1'b1 || tx_data !== prev_data) begin
                    n_bad++;
                    $display("FAIL hold_stable: got v=%b d=%h want v=1 d=%h", tx_valid, tx_data, prev_data);
                end
            end
            if (tx_valid === 1'b1 && tx_ready === 1'b1) begin
                n_acc++;
                n_chk++;
                if (q.size() == 0) begin
                    n_bad++;
                    $display("FAIL extra_byte: got %h want none", tx_data);
                end else begin
                    e = q.pop_front();
                    if (tx_data !== e.b) begin
                        n_bad++;
                        $display("FAIL byte: got %h want %h", tx_data, e.b);
                    end
                    exp_done = e.last;
                end
            end
            prev_stall = (tx_valid === 1'b1) && (tx_ready === 1'b0);
            prev_data  = tx_data;
        end else begin
            exp_done   = 1'b0;
            prev_stall = 1'b0;
        end
    end

    task automatic push_frame(input logic [15:0] t, input logic s);
        logic [10:0] m;
        logic [7:0]  f[9];
        int          ip, hd;
        m    = (t[15:11] != 5'd0) ? 11'h7FF : t[10:0];
        ip   = int'(m[10:4]);
        hd   = (int'(m[3:0]) * 25) / 4;
        f[0] = (s && m != 11'd0) ? 8'h2D : 8'h2B;
        f[1] = 8'(48 + ip / 100);
        f[2] = 8'(48 + (ip / 10) % 10);
        f[3] = 8'(48 + ip % 10);
        f[4] = 8'h2E;
        f[5] = 8'(48 + hd / 10);
        f[6] = 8'(48 + hd % 10);
        f[7] = 8'h0D;
        f[8] = 8'h0A;
        for (int i = 0; i < 9; i++) q.push_back('{f[i], i == 8});
    endtask

    task automatic start_pulse(input logic [15:0] t, input logic s);
        @(posedge clk);
        #1 temp_data = t; sign = s; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic wait_empty(input string name);
        int k = 0;
        while (q.size() != 0 && k < 400) begin
            @(posedge clk);
            k++;
        end
        n_chk++;
        if (q.size() != 0) begin
            n_bad++;
            $display("FAIL %s_timeout: got %0d bytes left want 0", name, q.size());
        end
        q.delete();
        repeat (3) @(posedge clk);
    endtask

    task automatic run_frame(input logic [15:0] t, input logic s, input string name);
        int base = n_done;
        push_frame(t, s);
        start_pulse(t, s);
        wait_empty(name);
        n_chk++;
        if (n_done != base + 1) begin
            n_bad++;
            $display("FAIL %s_done_count: got %0d want %0d", name, n_done - base, 1);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_chk++;
        if (tx_data !== 8'h00 || tx_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_state: got d=%h v=%b b=%b dn=%b want 00 0 0 0", tx_data, tx_valid, busy, done);
        end
        n_chk++;
        if (tx_valid2 !== 1'b0 || busy2 !== 1'b0 || done2 !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_state_bare: got v=%b b=%b dn=%b want 0 0 0", tx_valid2, busy2, done2);
        end
        rst = 1'b0;
    endtask

    task automatic test_basic();
        tx_ready = 1'b1;
        run_frame(16'h0191, 1'b0, "p25_06");
        run_frame(16'h07FF, 1'b0, "max");
        run_frame(16'h0FFF, 1'b0, "clamp");
        run_frame(16'h0000, 1'b1, "neg_zero");
        run_frame(16'hF000, 1'b1, "clamp_neg");
    endtask

    task automatic test_latency();
        int base = n_done;
        int lat = -1;
        push_frame(16'h00A8, 1'b1);
        @(posedge clk);
        #1 temp_data = 16'h00A8; sign = 1'b1; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        n_chk++;
        if (busy !== 1'b1) begin
            n_bad++;
            $display("FAIL busy_after_start: got %b want 1", busy);
        end
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk);
            #1;
            if (tx_valid === 1'b1 && lat < 0) lat = k;
        end
        n_chk++;
        if (lat != 8) begin
            n_bad++;
            $display("FAIL first_valid_latency: got %0d want 8", lat);
        end
        wait_empty("neg10_50");
        n_chk++;
        if (n_done != base + 1) begin
            n_bad++;
            $display("FAIL latency_done_count: got %0d want 1", n_done - base);
        end
    endtask

    task automatic test_stall();
        int         base = n_done;
        int         acc0 = n_acc;
        int         k = 0;
        int         bad_hold = 0;
        int         bad_idle = 0;
        logic [7:0] held;
        tx_ready = 1'b1;
        push_frame(16'h0191, 1'b0);
        start_pulse(16'h0191, 1'b0);
        while (n_acc < acc0 + 3 && k < 100) begin
            @(posedge clk);
            k++;
        end
        #1 tx_ready = 1'b0;
        held = tx_data;
        n_chk++;
        if (held !== 8'h35 || tx_valid !== 1'b1) begin
            n_bad++;
            $display("FAIL stall_fourth_byte: got v=%b d=%h want 1 35", tx_valid, held);
        end
        for (int c = 0; c < 20; c++) begin
            start = (c == 4 || c == 11);
            @(posedge clk);
            #1 start = 1'b0;
            if (tx_valid !== 1'b1 || tx_data !== held || busy !== 1'b1) bad_hold++;
        end
        n_chk++;
        if (bad_hold != 0) begin
            n_bad++;
            $display("FAIL stall_hold: got %0d bad cycles want 0", bad_hold);
        end
        tx_ready = 1'b1;
        wait_empty("stall");
        for (int c = 0; c < 30; c++) begin
            @(posedge clk);
            #1;
            if (tx_valid !== 1'b0 || busy !== 1'b0) bad_idle++;
        end
        n_chk++;
        if (bad_idle != 0) begin
            n_bad++;
            $display("FAIL no_second_frame: got %0d active cycles want 0", bad_idle);
        end
        n_chk++;
        if (n_done != base + 1) begin
            n_bad++;
            $display("FAIL stall_done_count: got %0d want 1", n_done - base);
        end
    endtask

    task automatic test_reset_mid();
        int base = n_done;
        int acc0 = n_acc;
        int k = 0;
        tx_ready = 1'b1;
        push_frame(16'h07FF, 1'b0);
        start_pulse(16'h07FF, 1'b0);
        while (n_acc < acc0 + 4 && k < 100) begin
            @(posedge clk);
            k++;
        end
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        n_chk++;
        if (tx_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
            n_bad++;
            $display("FAIL mid_reset: got v=%b b=%b dn=%b want 0 0 0", tx_valid, busy, done);
        end
        q.delete();
        repeat (20) @(posedge clk);
        n_chk++;
        if (n_done != base) begin
            n_bad++;
            $display("FAIL mid_reset_done: got %0d want 0", n_done - base);
        end
        run_frame(16'h0191, 1'b0, "after_reset");
    endtask

    task automatic test_bare();
        logic [7:0] want[7];
        logic [7:0] got[$];
        int         nd = 0;
        want = '{8'h2B, 8'h30, 8'h30, 8'h30, 8'h2E, 8'h30, 8'h30};
        @(posedge clk);
        #1 temp2 = 16'h0000; sign2 = 1'b1; start2 = 1'b1;
        @(posedge clk);
        #1 start2 = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk);
            #1;
            if (tx_valid2 === 1'b1) got.push_back(tx_data2);
            if (done2 === 1'b1) nd++;
        end
        n_chk++;
        if (got.size() != 7) begin
            n_bad++;
            $display("FAIL bare_len: got %0d want 7", got.size());
        end
        for (int i = 0; i < 7 && i < got.size(); i++) begin
            n_chk++;
            if (got[i] !== want[i]) begin
                n_bad++;
                $display("FAIL bare_byte%0d: got %h want %h", i, got[i], want[i]);
            end
        end
        n_chk++;
        if (nd != 1) begin
            n_bad++;
            $display("FAIL bare_done: got %0d want 1", nd);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_latency();
        test_stall();
        test_reset_mid();
        test_bare();
        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
